mux2to1_arbiter: RTL and testbench
==================================

Name: mux2to1_arbiter

Overview:
- Round-robin arbiter that shares one 2-to-1 CMOS pass-gate multiplexer between two requesters.
- Generates the mux select `s` and an output-enable `en` with a break-before-make dead time, so the pass gates never switch while the shared output is live.
- Sits directly in front of the 2:1 mux; its `s` drives the mux select, and `en` gates the downstream consumer of `y`.

Parameters:
- DEAD_CYCLES, 1, cycles that `en` stays low after `s` changes before a grant is issued; legal range 1..15.
- MAX_HOLD, 8, cycles a grant may be held while the other channel is requesting; legal range 1..255; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  channel 0 request; held high for as long as the channel wants the mux
- req1  input  1  channel 1 request; same rules as req0
- gnt0  output  1  channel 0 owns the mux
- gnt1  output  1  channel 1 owns the mux
- s  output  1  mux select; 0 selects a0, 1 selects a1
- en  output  1  shared output valid; always equal to gnt0|gnt1

Behaviour:
- One clock domain. Reset is synchronous and active-high; all state is registered on the rising edge of clk.
- Reset values: gnt0=0, gnt1=0, en=0, s=0, state=IDLE, last=1, dead counter=0, hold counter=0. Because last resets to 1, channel 0 wins the first tie.
- rst asserted in any state returns every output and register to its reset value at the next edge; a grant in progress is dropped with no dead time.
- States: IDLE, SETTLE, GRANT.
- IDLE: en=0, gnt=00, s holds its previous value.
  - One request high: target = that channel.
  - Both high: target = !last.
  - At the next edge: s <= target, dead counter <= DEAD_CYCLES-1, go to SETTLE.
- SETTLE: en=0, gnt=00, s stable.
  - Dead counter decrements each cycle; when it is 0, evaluate the target request.
  - Target req high: go to GRANT; gnt_target=1, en=1, last<=target, hold counter<=0.
  - Target req low: the request was withdrawn, so go to IDLE and leave last unchanged.
  - Requests changing during SETTLE never change s.
- Latency: with req sampled high in IDLE at edge N, s updates at N+1 and gnt/en assert at N+1+DEAD_CYCLES (N+2 at default).
- GRANT: gnt_target=1, en=1, s constant.
  - Owner req low at an edge: gnt and en drop at that edge.
    - Other req high: s <= other, enter SETTLE.
    - Otherwise: go to IDLE.
  - Owner re-raising req on the cycle after release gets no priority; normal round-robin applies.
- Invariants, checked every cycle:
  - gnt0 & gnt1 == 0.
  - en == (gnt0 | gnt1).
  - s never changes in a cycle where en is 1, or in the cycle in which en rises.
  - While gnt1=1, s == 1; while gnt0=1, s == 0.
- Counter widths: dead counter 4 bits; hold counter 8 bits, saturating, never wraps.

Optional Feature:
- Macro: MUX2TO1_ARBITER_HOLD_LIMIT_EN.
- Defined:
  - In GRANT, the hold counter increments each cycle the other channel's req is high and resets to 0 when it is low.
  - When the counter reaches MAX_HOLD-1 and the other req is still high, the owner is forcibly released at the next edge even if its req is high: gnt and en drop, s flips, enter SETTLE for the other channel.
  - The preempted requester simply keeps req high and is re-granted later by round-robin.
- Undefined:
  - No hold counter is synthesized.
  - A grant lasts until the owner drops req, so starvation of the other channel is possible by design.

Test Plan:
- Reset: assert rst for 2 cycles with req0=req1=1 -> gnt=00, en=0, s=0 throughout. After release, s=0 next edge, then gnt0=1 and en=1 one cycle later (DEAD_CYCLES=1).
- Single requester: req1 pulsed high for 5 cycles from IDLE -> s=1 at N+1, gnt1=1 for cycles N+2..N+5, gnt1 and en drop at the edge where req1 is sampled low, then IDLE.
- Tie/round-robin: both reqs held high, each owner drops req for 1 cycle after 3 cycles of grant -> grants alternate 0,1,0,1. en is low exactly DEAD_CYCLES cycles between grants. gnt0&gnt1 never 1.
- Withdrawal during SETTLE: DEAD_CYCLES=3, req0 high for 2 cycles only -> s=0, en never rises, return to IDLE, last unchanged, so the next tie still goes to channel 0.
- Mid-grant reset: rst asserted while gnt1=1 -> at the next edge gnt1=0, en=0, s=0, IDLE.
- Hold limit (macro defined, MAX_HOLD=4): req0 and req1 held high continuously -> gnt0 held for exactly 4 cycles, 1 dead cycle, gnt1 for 4 cycles, repeating. With the macro undefined, gnt0 is held indefinitely.

Source files
------------

// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter driving the select of a shared 2:1 pass-gate mux, with break-before-make dead time.
// Optional forced release after MAX_HOLD contended cycles: define MUX2TO1_ARBITER_HOLD_LIMIT_EN.
module mux2to1_arbiter #(
    parameter int DEAD_CYCLES = 1,
    parameter int MAX_HOLD    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic s,
    output logic en
);

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 15) begin : g_bad_dead
        $error("DEAD_CYCLES must be in 1..15");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_e;

    localparam logic [3:0] DEAD_INIT = 4'(DEAD_CYCLES - 1);

    state_e     state_q, state_d;
    logic       s_q, s_d;
    logic       last_q, last_d;
    logic [3:0] dcnt_q, dcnt_d;
    logic       req_tgt, req_oth, release_own;

    // s_q always names the target/owner channel outside IDLE
    assign req_tgt = s_q ? req1 : req0;
    assign req_oth = s_q ? req0 : req1;

`ifdef MUX2TO1_ARBITER_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hcnt_q, hcnt_d;

    assign release_own = !req_tgt || (req_oth && hcnt_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) hcnt_q <= 8'd0;
        else     hcnt_q <= hcnt_d;
    end
`else
    assign release_own = !req_tgt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
            dcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            last_q  <= last_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        last_d  = last_q;
        dcnt_d  = dcnt_q;
`ifdef MUX2TO1_ARBITER_HOLD_LIMIT_EN
        hcnt_d  = hcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    s_d     = (req0 && req1) ? ~last_q : req1;
                    dcnt_d  = DEAD_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (dcnt_q != 4'd0) begin
                    dcnt_d = dcnt_q - 4'd1;
                end else if (req_tgt) begin
                    state_d = GRANT;
                    last_d  = s_q;
`ifdef MUX2TO1_ARBITER_HOLD_LIMIT_EN
                    hcnt_d  = 8'd0;
`endif
                end else begin
                    // withdrawn during dead time: last stays as it was
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_own) begin
                    if (req_oth) begin
                        s_d     = ~s_q;
                        dcnt_d  = DEAD_INIT;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef MUX2TO1_ARBITER_HOLD_LIMIT_EN
                else if (!req_oth)       hcnt_d = 8'd0;
                else if (hcnt_q != 8'hFF) hcnt_d = hcnt_q + 8'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en   = (state_q == GRANT);
        gnt0 = en & ~s_q;
        gnt1 = en & s_q;
        s    = s_q;
    end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Bench: two arbiters (dead time 1 and 3) on shared requests, checked every cycle against a timeline model.
module tb_mux2to1_arbiter;

`ifdef MUX2TO1_ARBITER_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam int MAXH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic [1:0] g0, g1, sv, ev;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int dead[2] = '{1, 3};

    // model: owner (-1 none), select, edge at which a pending target is decided, last winner, contended hold count
    int m_own[2], m_sel[2], m_dec[2], m_last[2], m_held[2];
    logic [1:0] s_prev = 2'b00;

    always #5 clk = ~clk;

    mux2to1_arbiter #(.DEAD_CYCLES(1), .MAX_HOLD(MAXH)) u_dut_a (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .gnt0(g0[0]), .gnt1(g1[0]), .s(sv[0]), .en(ev[0]));

    mux2to1_arbiter #(.DEAD_CYCLES(3), .MAX_HOLD(MAXH)) u_dut_b (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .gnt0(g0[1]), .gnt1(g1[1]), .s(sv[1]), .en(ev[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int k, input bit r0, input bit r1, input bit rr);
        bit rq[2];
        int o;
        bit cut;
        rq[0] = r0;
        rq[1] = r1;
        if (rr) begin
            m_own[k] = -1; m_sel[k] = 0; m_dec[k] = -1; m_last[k] = 1; m_held[k] = 0;
        end else if (m_own[k] >= 0) begin
            o   = m_own[k];
            cut = !rq[o] || (HOLD_EN && rq[1-o] && m_held[k] >= MAXH - 1);
            if (cut) begin
                m_own[k] = -1;
                if (rq[1-o]) begin
                    m_sel[k] = 1 - o;
                    m_dec[k] = cyc + dead[k];
                end
            end else begin
                m_held[k] = rq[1-o] ? ((m_held[k] < 255) ? m_held[k] + 1 : 255) : 0;
            end
        end else if (m_dec[k] >= 0) begin
            if (cyc == m_dec[k]) begin
                if (rq[m_sel[k]]) begin
                    m_own[k]  = m_sel[k];
                    m_last[k] = m_sel[k];
                    m_held[k] = 0;
                end
                m_dec[k] = -1;
            end
        end else if (rq[0] || rq[1]) begin
            m_sel[k] = (rq[0] && rq[1]) ? 1 - m_last[k] : (rq[1] ? 1 : 0);
            m_dec[k] = cyc + dead[k];
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt0_%0d", k), 32'(g0[k]), 32'(m_own[k] == 0));
            chk($sformatf("gnt1_%0d", k), 32'(g1[k]), 32'(m_own[k] == 1));
            chk($sformatf("en_%0d", k),   32'(ev[k]), 32'(m_own[k] >= 0));
            chk($sformatf("s_%0d", k),    32'(sv[k]), 32'(m_sel[k]));
            chk($sformatf("excl_%0d", k), 32'(g0[k] & g1[k]), 32'd0);
            chk($sformatf("en_or_%0d", k), 32'(ev[k]), 32'(g0[k] | g1[k]));
            if (ev[k]) chk($sformatf("s_hold_%0d", k), 32'(sv[k]), 32'(s_prev[k]));
        end
        s_prev = sv;
    endtask

    task automatic step(input bit r0, input bit r1, input bit rr);
        @(negedge clk);
        req0 = r0; req1 = r1; rst = rr;
        @(posedge clk);
        cyc++;
        model_step(0, r0, r1, rr);
        model_step(1, r0, r1, rr);
        #1;
        compare_all();
    endtask

    initial begin
        bit r0, r1;
        // reset held with both requests up
        step(1, 1, 1);
        step(1, 1, 1);
        chk("rst_gnt", 32'({g1[0], g0[0]}), 32'd0);
        chk("rst_s", 32'(sv[0]), 32'd0);
        step(1, 1, 0);
        chk("rel_s", 32'(sv[0]), 32'd0);
        chk("rel_en_lo", 32'(ev[0]), 32'd0);
        step(1, 1, 0);
        chk("rel_gnt0", 32'(g0[0]), 32'd1);
        // round robin with brief owner drops
        for (int i = 0; i < 24; i++) step((i % 5) != 3, (i % 7) != 5, 0);

        // single requester on channel 1, then reset mid-grant
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(0, 1, 0);
        chk("single_s", 32'(sv[0]), 32'd1);
        step(0, 1, 0);
        chk("single_gnt1", 32'(g1[0]), 32'd1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("single_gnt1_last", 32'(g1[0]), 32'd1);
        step(0, 0, 0);
        chk("single_drop", 32'(ev[0]), 32'd0);
        step(0, 1, 0);
        step(0, 1, 0);
        chk("pre_rst_gnt1", 32'(g1[0]), 32'd1);
        step(0, 1, 1);
        chk("mid_rst_gnt1", 32'(g1[0]), 32'd0);
        chk("mid_rst_s", 32'(sv[0]), 32'd0);

        // withdrawal during dead time on the 3-cycle instance
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0);
            chk("wd_en", 32'(ev[1]), 32'd0);
        end
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        chk("wd_tie_gnt0", 32'(g0[1]), 32'd1);

        // continuous contention: hold limit or indefinite grant
        for (int i = 0; i < 30; i++) step(1, 1, 0);

        // randomized phase
        r0 = 0; r1 = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) r0 = ~r0;
            if ($urandom_range(5) == 0) r1 = ~r1;
            step(r0, r1, $urandom_range(149) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
